// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: loads a cache line from a synchronous-read RAM, returning the
// critical word first and wrapping within the line. It also handles
// single-word writes. The RAM address, write data and write enable are all
// registered.
module line_fill_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32,
    parameter int LBITS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              fill_valid,
    input  logic              fill_ready,
    output logic [DWIDTH-1:0] fill_data,
    output logic [LBITS-1:0]  fill_idx,
    output logic              fill_last,
    output logic              wr_done
);

    typedef enum logic [1:0] {IDLE, RADDR, RDATA, WRITE} state_t;

    state_t           state, state_nxt;
    logic [LBITS-1:0] cnt;     // words already handed out in this fill
    logic             last;

    // The word offset lives in mem_addr's low bits. The critical word
    // therefore seeds it directly, and no separate offset register is kept.
    assign last       = (cnt == {LBITS{1'b1}});
    assign req_ready  = (state == IDLE);
    assign fill_valid = (state == RDATA);
    assign fill_data  = fill_valid ? mem_dout : '0;
    assign fill_idx   = fill_valid ? mem_addr[LBITS-1:0] : '0;
    assign fill_last  = fill_valid && last;
    assign wr_done    = (state == WRITE);

    // State register; reset aborts any fill or write in flight.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: one address cycle plus one data cycle per word, and a
    // single-cycle write.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_we ? WRITE : RADDR;
            RADDR:   state_nxt = RDATA;
            RDATA:   if (fill_ready) state_nxt = last ? IDLE : RADDR;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM-side registers and word counter. mem_addr is held through RDATA,
    // so the read data stays stable for as long as the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    mem_addr <= req_addr;
                    if (req_we) begin
                        mem_din <= req_wdata;
                        mem_we  <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                WRITE: mem_we <= 1'b0;
                RDATA: if (fill_ready && !last) begin
                    // The offset wraps within the line; the line bits stay put.
                    mem_addr[LBITS-1:0] <= mem_addr[LBITS-1:0] + LBITS'(1);
                    cnt                 <= cnt + LBITS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/line_fill_ctrl.md
LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 Parameter AWIDTH, default 3, word address width into the synchronous-read data RAM.
REQ-002 Parameter DWIDTH, default 32, data word width.
REQ-003 Parameter LBITS, default 1, log2 of words per line (1 <= LBITS < AWIDTH); WPL = 2**LBITS.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_we  in  1  1 = single-word write, 0 = line fill.
REQ-010 req_addr  in  AWIDTH  word address: fill = critical word; write = target word.
REQ-011 req_wdata  in  DWIDTH  write data.
REQ-012 mem_addr  out  AWIDTH  registered RAM address.
REQ-013 mem_din  out  DWIDTH  registered RAM write data.
REQ-014 mem_we  out  1  registered RAM write enable.
REQ-015 mem_dout  in  DWIDTH  RAM read data: one-cycle synchronous read of the address sampled at the previous edge.
REQ-016 fill_valid  out  1  fill word valid.
REQ-017 fill_ready  in  1  consumer accepts fill word.
REQ-018 fill_data  out  DWIDTH  fill word, combinationally equal to mem_dout while fill_valid.
REQ-019 fill_idx  out  LBITS  word offset within the line of fill_data.
REQ-020 fill_last  out  1  current fill word is the final word of the line.
REQ-021 wr_done  out  1  high for the cycle in which mem_we is asserted.

Function
REQ-022 The FSM SHALL have four states: IDLE, RADDR, RDATA and WRITE. req_ready = 1 only in IDLE.
REQ-023 A request is accepted on an edge where req_valid & req_ready; req_* SHALL be sampled only then.
REQ-024 IDLE + accepted fill: mem_addr <= req_addr, cnt <= 0, start offset <= req_addr[LBITS-1:0]; go to RADDR.
REQ-025 IDLE + accepted write: mem_addr <= req_addr, mem_din <= req_wdata, mem_we <= 1; go to WRITE.
REQ-026 WRITE lasts exactly one cycle (mem_we = 1, wr_done = 1); next edge: mem_we <= 0, go to IDLE.
REQ-027 RADDR lasts exactly one cycle with mem_addr held; then go to RDATA.
REQ-028 RDATA: fill_valid = 1 and mem_addr is held, so mem_dout stays stable under backpressure indefinitely.
REQ-029 RDATA, fill_ready = 0: hold all state and outputs.
REQ-030 RDATA, fill_ready = 1, not last: mem_addr low LBITS <= offset + 1 mod WPL, upper bits unchanged (critical-word-first, wrap within line); cnt <= cnt + 1; go to RADDR.
REQ-031 RDATA, fill_ready = 1, last: go to IDLE.
REQ-032 fill_idx = mem_addr[LBITS-1:0]; fill_last = (cnt == WPL-1); both are 0 outside RDATA.
REQ-033 Timing: the first fill word is valid 2 cycles after the accept edge; with fill_ready held at 1, one word every 2 cycles and 2*WPL busy cycles per fill.
REQ-034 mem_we SHALL never be 1 in RADDR or RDATA; a fill never modifies the RAM.
REQ-035 req_valid in non-IDLE states is ignored (not dropped: stays pending until req_ready).
REQ-036 Back-to-back: a request may be accepted in the first IDLE cycle after a fill or write completes.

Reset
REQ-037 On reset: state = IDLE; mem_addr = 0, mem_din = 0, mem_we = 0, fill_valid = 0, fill_idx = 0, fill_last = 0, wr_done = 0, cnt = 0; req_ready = 1 the cycle after reset deasserts.
REQ-038 Reset mid-fill or mid-write SHALL abort immediately with no further words or writes. RAM contents already written are unaffected.

Verification
REQ-039 Setup: LBITS = 2, mem[4..7] = 0xA4..0xA7. Fill req_addr = 6, fill_ready = 1 -> words 0xA6/idx2, 0xA7/idx3, 0xA4/idx0, 0xA5/idx1 (last) at cycles 2, 4, 6, 8; req_ready = 1 at cycle 9.
REQ-040 Same fill with fill_ready = 0 for 5 cycles on the 2nd word -> fill_data stays 0xA7, idx 3, until accepted; no word is lost or duplicated.
REQ-041 Write req_addr = 5, wdata = 0xDEADBEEF, then immediately fill req_addr = 4 -> mem_we = 1 for exactly 1 cycle; the fill returns 0xA4, 0xDEADBEEF, 0xA6, 0xA7.
REQ-042 Assert reset during the 2nd RDATA of a fill -> next cycle fill_valid = 0, mem_we = 0, req_ready = 1; a new fill completes correctly.
REQ-043 Hold req_valid = 1 (write) throughout a fill -> the write is accepted only in the IDLE cycle after fill_last handshakes.
REQ-044 Fill req_addr = 7 (last word of the top line) -> addresses 7, 4, 5, 6; mem_addr never leaves 4..7.
